// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register step controller.
//   - Debounce FSM state encoding.
//   - Default step periods (LIMIT_R0..R3) and debounce confirmation length.
package shift_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE            = 2'd0,
      ST_CONFIRM_PRESS   = 2'd1,
      ST_PRESSED         = 2'd2,
      ST_CONFIRM_RELEASE = 2'd3
   } dbnc_state_e;

   localparam int DEF_LIMIT_R0        = 16;
   localparam int DEF_LIMIT_R1        = 32;
   localparam int DEF_LIMIT_R2        = 64;
   localparam int DEF_LIMIT_R3        = 128;
   localparam int DEF_DEBOUNCE_CYCLES = 8;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a debounce FSM.
// Emits a single-cycle press event once the synchronized button has been
// high for DEBOUNCE_CYCLES consecutive samples; releases are silent.
// Ports:
//   clock    in   single rising-edge clock
//   i_reset  in   synchronous active-high reset
//   i_btn    in   raw asynchronous button, active-high
//   o_press  out  one-cycle press event (combinational from registered state)
module btn_debounce
   import shift_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES  // must be >= 2
) (
   input  logic clock,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // The sample that opens a confirm state is already counted as 1, so the
   // final confirming sample arrives while the count reads DEBOUNCE_CYCLES-1.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   dbnc_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = i_btn;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      o_press = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sync2_q) begin
               state_d = ST_CONFIRM_PRESS;
               cnt_d   = CNT_ONE;
            end
         end
         ST_CONFIRM_PRESS: begin
            if (!sync2_q) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
               o_press = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!sync2_q) begin
               state_d = ST_CONFIRM_RELEASE;
               cnt_d   = CNT_ONE;
            end
         end
         ST_CONFIRM_RELEASE: begin
            if (sync2_q) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/shift_ctrl.sv
// Step controller for a reversible shift register.
// A rate counter issues a one-cycle step strobe every LIMIT(sel) cycles while
// enabled; a debounced reverse button raises a pending request that is shown
// on o_reverse and consumed by the next step.
// Ports:
//   clock       in   single rising-edge clock
//   i_reset     in   synchronous active-high reset
//   i_enable    in   1 = stepping runs, 0 = counter holds
//   i_rate_sel  in   [1:0] selects LIMIT_R0..LIMIT_R3
//   i_btn_rev   in   raw asynchronous reverse button, active-high
//   o_valid     out  one-cycle step strobe
//   o_reverse   out  pending direction-toggle request
module shift_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int NB_COUNTER      = 32,
   parameter int LIMIT_R0        = DEF_LIMIT_R0,
   parameter int LIMIT_R1        = DEF_LIMIT_R1,
   parameter int LIMIT_R2        = DEF_LIMIT_R2,
   parameter int LIMIT_R3        = DEF_LIMIT_R3,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic       clock,
   input  logic       i_reset,
   input  logic       i_enable,
   input  logic [1:0] i_rate_sel,
   input  logic       i_btn_rev,
   output logic       o_valid,
   output logic       o_reverse
);

   logic [NB_COUNTER-1:0] cnt_q, cnt_d;
   logic [NB_COUNTER-1:0] limit_m1;
   logic                  valid_q, valid_d;
   logic                  pend_q, pend_d;
   logic                  step;
   logic                  press;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_debounce (
      .clock   (clock),
      .i_reset (i_reset),
      .i_btn   (i_btn_rev),
      .o_press (press)
   );

   always_comb begin
      case (i_rate_sel)
         2'd0:    limit_m1 = NB_COUNTER'(LIMIT_R0 - 1);
         2'd1:    limit_m1 = NB_COUNTER'(LIMIT_R1 - 1);
         2'd2:    limit_m1 = NB_COUNTER'(LIMIT_R2 - 1);
         default: limit_m1 = NB_COUNTER'(LIMIT_R3 - 1);
      endcase
   end

   always_comb begin
      // ">=" rather than "==" so that switching to a shorter period while the
      // counter is already past it steps immediately instead of wrapping.
      step    = i_enable && (cnt_q >= limit_m1);
      valid_d = step;
      cnt_d   = cnt_q;
      if (step)
         cnt_d = '0;
      else if (i_enable)
         cnt_d = cnt_q + 1'b1;
      // A step cycle (valid_q) consumes the request; a press in that same
      // cycle re-arms it for the following step.
      pend_d = press | (pend_q & ~valid_q);
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         pend_q  <= pend_d;
      end
   end

   assign o_valid   = valid_q;
   assign o_reverse = pend_q;

endmodule

// File: tb/tb_shift_ctrl.sv
module tb_shift_ctrl;

   localparam int DB = 8;

   logic       clock = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_enable = 1'b0;
   logic [1:0] i_rate_sel = 2'd0;
   logic       i_btn_rev = 1'b0;
   logic       o_valid;
   logic       o_reverse;

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   // reference model state
   int m_cnt = 0;
   int m_run = 0;
   bit m_valid = 0, m_pend = 0, m_deb = 0, m_s1 = 0, m_s2 = 0;

   // scenario bookkeeping
   int  npulse, nmis, rev_seen, first_at, hold;
   bit  v_at [0:200];
   bit  r_at [0:200];

   shift_ctrl dut (
      .clock      (clock),
      .i_reset    (i_reset),
      .i_enable   (i_enable),
      .i_rate_sel (i_rate_sel),
      .i_btn_rev  (i_btn_rev),
      .o_valid    (o_valid),
      .o_reverse  (o_reverse)
   );

   always #5 clock = ~clock;

   function automatic int lim(input logic [1:0] s);
      return 16 << s;
   endfunction

   // One clock edge as seen by the reference: the button is accepted once the
   // synchronized level has differed from the debounced level for DB samples.
   task automatic model_step();
      bit press;
      bit step;
      bit consumed;
      press = 0;
      if (i_reset) begin
         m_cnt = 0; m_run = 0; m_valid = 0; m_pend = 0;
         m_deb = 0; m_s1 = 0; m_s2 = 0;
      end else begin
         if (m_s2 != m_deb) m_run++; else m_run = 0;
         if (m_run == DB) begin
            m_deb = !m_deb;
            m_run = 0;
            press = m_deb;
         end
         step     = i_enable && (m_cnt + 1 >= lim(i_rate_sel));
         consumed = m_valid && m_pend;
         m_pend   = press || (m_pend && !consumed);
         m_valid  = step;
         m_cnt    = step ? 0 : (i_enable ? m_cnt + 1 : m_cnt);
         m_s2     = m_s1;
         m_s1     = i_btn_rev;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step();
      edge_n++;
      #1;
      total++;
      assert (o_valid === m_valid) else begin
         bad++;
         $error("FAIL o_valid edge=%0d got=%0b exp=%0b", edge_n, o_valid, m_valid);
      end
      total++;
      assert (o_reverse === m_pend) else begin
         bad++;
         $error("FAIL o_reverse edge=%0d got=%0b exp=%0b", edge_n, o_reverse, m_pend);
      end
   endtask

   task automatic check(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
   endtask

   initial begin
      // ---- reset state and steady stepping at sel=0 ----
      i_btn_rev = 1'b0;
      do_reset();
      check("reset_valid", int'(o_valid), 0);
      check("reset_reverse", int'(o_reverse), 0);
      i_enable = 1'b1; i_rate_sel = 2'd0;
      npulse = 0; nmis = 0; rev_seen = 0;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (o_valid) begin
            npulse++;
            if (i % 16 != 0) nmis++;
         end
         if (o_reverse) rev_seen++;
      end
      check("period16_pulses", npulse, 6);
      check("period16_misplaced", nmis, 0);
      check("period16_no_reverse", rev_seen, 0);

      // ---- clean press: o_reverse rises 10 edges after the button ----
      i_btn_rev = 1'b1;
      first_at = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (o_reverse && first_at < 0) first_at = i;
      end
      check("press_latency", first_at, 10);
      i_btn_rev = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      check("press_consumed", int'(o_reverse), 0);

      // ---- glitches shorter than the debounce window ----
      rev_seen = 0;
      for (int g = 0; g < 2; g++) begin
         i_btn_rev = 1'b1;
         for (int i = 0; i < 5; i++) begin tick(); if (o_reverse) rev_seen++; end
         i_btn_rev = 1'b0;
         for (int i = 0; i < 5; i++) begin tick(); if (o_reverse) rev_seen++; end
      end
      for (int i = 0; i < 20; i++) begin tick(); if (o_reverse) rev_seen++; end
      check("glitch_no_reverse", rev_seen, 0);

      // ---- rate switch with counter past the new limit ----
      do_reset();
      i_enable = 1'b1; i_rate_sel = 2'd3;
      for (int i = 0; i < 70; i++) tick();
      i_rate_sel = 2'd0;
      tick();
      check("switch_immediate_step", int'(o_valid), 1);
      first_at = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (o_valid && first_at < 0) first_at = i;
      end
      check("switch_then_period", first_at, 16);

      // ---- collapse of two presses, press coinciding with a step ----
      do_reset();
      i_enable = 1'b1; i_rate_sel = 2'd2;
      for (int e = 1; e <= 200; e++) begin
         i_btn_rev = ((e >= 1 && e <= 12) || (e >= 25 && e <= 36) ||
                      (e >= 71 && e <= 82) || (e >= 120 && e <= 131));
         tick();
         v_at[e] = o_valid;
         r_at[e] = o_reverse;
      end
      i_btn_rev = 1'b0;
      check("first_press_pending", int'(r_at[10]), 1);
      check("step64", int'(v_at[64]), 1);
      check("collapsed_after_step", int'(r_at[65]), 0);
      check("step128", int'(v_at[128]), 1);
      check("set_beats_clear", int'(r_at[129]), 1);
      check("step192", int'(v_at[192]), 1);
      check("consumed_at_193", int'(r_at[193]), 0);

      // ---- pending held while disabled, then reset mid-period ----
      for (int i = 0; i < 20; i++) tick();
      do_reset();
      i_enable = 1'b1; i_rate_sel = 2'd0;
      for (int i = 0; i < 3; i++) tick();
      i_enable = 1'b0;
      npulse = 0;
      for (int i = 1; i <= 50; i++) begin
         i_btn_rev = (i <= 12);
         tick();
         if (o_valid) npulse++;
      end
      check("disabled_no_step", npulse, 0);
      check("disabled_reverse_held", int'(o_reverse), 1);
      i_enable = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("reverse_before_reset", int'(o_reverse), 1);
      do_reset();
      check("reset_clears_reverse", int'(o_reverse), 0);
      first_at = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (o_valid && first_at < 0) first_at = i;
      end
      check("first_step_after_reset", first_at, 16);

      // ---- randomized traffic against the reference ----
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            i_btn_rev = ~i_btn_rev;
            hold = $urandom_range(1, 16);
         end else begin
            hold--;
         end
         if ($urandom_range(0, 63) == 0) i_rate_sel = 2'($urandom_range(0, 3));
         i_enable = ($urandom_range(0, 9) != 0);
         i_reset  = ($urandom_range(0, 399) == 0);
         tick();
      end
      i_reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 SHALL have parameter NB_COUNTER, default 32, width of the rate counter.
REQ-002 SHALL have parameters LIMIT_R0..LIMIT_R3, defaults 16/32/64/128, step period in clock cycles for rate selects 0..3.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 8, the number of consecutive stable synchronized samples that confirms a button edge.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clock  input  1  single clock, all logic on rising edge.
REQ-005 i_reset  input  1  synchronous active-high reset.
REQ-006 i_enable  input  1  1 = stepping runs; 0 = counter holds, no steps issued.
REQ-007 i_rate_sel  input  2  selects LIMIT_R0..LIMIT_R3.
REQ-008 i_btn_rev  input  1  raw asynchronous reverse push-button, active-high.
REQ-009 o_valid  output  1  one-cycle step strobe, drives the shift-register enable.
REQ-010 o_reverse  output  1  pending direction-toggle request, drives the shift-register reverse input.

Function
REQ-011 Rate counter SHALL increment each cycle while i_enable=1 and SHALL hold while i_enable=0.
REQ-012 On the edge where i_enable=1 and counter >= LIMIT(sel)-1, the counter SHALL load 0 and o_valid SHALL be registered to 1 for exactly one cycle; otherwise o_valid is registered to 0.
REQ-013 Step period SHALL be exactly LIMIT(sel) cycles at a constant select; first o_valid after reset SHALL appear after LIMIT(sel) rising edges with i_reset=0 and i_enable=1.
REQ-014 A change of i_rate_sel SHALL take effect on the next edge; if the counter already is >= the new LIMIT-1, a step SHALL issue on that edge (no wrap past 2^NB_COUNTER).
REQ-015 i_btn_rev SHALL pass a 2-flop synchronizer before any use.
REQ-016 Debouncer FSM states SHALL be IDLE, CONFIRM_PRESS, PRESSED, CONFIRM_RELEASE.
REQ-017 IDLE->CONFIRM_PRESS on synchronized 1; CONFIRM_PRESS->IDLE on any 0; CONFIRM_PRESS->PRESSED after DEBOUNCE_CYCLES consecutive 1s, emitting a single-cycle press event.
REQ-018 PRESSED->CONFIRM_RELEASE on 0; CONFIRM_RELEASE->PRESSED on any 1; CONFIRM_RELEASE->IDLE after DEBOUNCE_CYCLES consecutive 0s; no event on release.
REQ-019 Press event SHALL set a pending flag; o_reverse SHALL equal the registered pending flag.
REQ-020 Pending flag SHALL clear on the edge ending a cycle with o_valid=1 and o_reverse=1 (request consumed by that step).
REQ-021 Press event coinciding with the consuming o_valid cycle SHALL leave pending set (set beats clear), applying to the next step.
REQ-022 Multiple press events before one step SHALL collapse into one request.
REQ-023 o_reverse SHALL hold and not be lost while i_enable=0.

Reset
REQ-024 On i_reset=1: counter=0, o_valid=0, o_reverse=0, pending=0, FSM=IDLE, debounce count=0, synchronizer flops=0.
REQ-025 Reset asserted mid-period or mid-debounce SHALL discard partial counts and any pending request; the first step after release follows REQ-013.

Structure
REQ-026 Package shift_ctrl_pkg SHALL hold the FSM state encoding and the default LIMIT_R* and DEBOUNCE_CYCLES constants.
REQ-027 Synchronizer plus debounce FSM SHALL be sub-module btn_debounce (outputs press event); the rate counter and pending flag stay in shift_ctrl.

Verification
REQ-028 Reset, enable=1, sel=0, hold 100 cycles -> o_valid pulses of width 1 at cycles 16,32,48,64,80,96; o_reverse=0 throughout.
REQ-029 Button high 20 cycles -> o_reverse rises 2+8 edges after the button rises, stays 1 until the next o_valid cycle, falls on the following edge.
REQ-030 Button glitch high 5 cycles, twice -> no press event, o_reverse stays 0.
REQ-031 sel=3 with counter at 70, switch to sel=0 -> o_valid on the next edge, then period 16.
REQ-032 Two debounced presses between steps, then press event timed on an o_valid cycle -> one request consumed per step, final request pending for the next step.
REQ-033 enable=0 for 50 cycles with pending set, then reset mid-period -> no o_valid while disabled, o_reverse held at 1, cleared to 0 by reset, first step 16 edges after reset release.
